// File: rtl/gen_ctrl_pkg.sv
// Shared definitions for the PCIe generation/rate controller: generation
// encodings, FSM state encodings and the per-lane PIPE width lookup.
package gen_ctrl_pkg;

   // Generation encodings as presented on the gen input
   localparam logic [2:0] GEN1 = 3'b000;
   localparam logic [2:0] GEN2 = 3'b001;
   localparam logic [2:0] GEN3 = 3'b010;
   localparam logic [2:0] GEN4 = 3'b011;
   localparam logic [2:0] GEN5 = 3'b100;

   // Controller state encodings
   localparam logic [1:0] ST_HOLD  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   // True for the five defined generation codes
   function automatic logic gen_legal(input logic [2:0] g);
      return (g <= GEN5);
   endfunction

   // PIPE bits per lane for a generation; anything unknown falls back to Gen1.
   // Widths default to the standard PIPE values but callers pass their own.
   function automatic int pipewidth(input logic [2:0] g,
                                    input int w1 = 8,
                                    input int w2 = 16,
                                    input int w3 = 32,
                                    input int w4 = 8,
                                    input int w5 = 8);
      case (g)
         GEN2:    return w2;
         GEN3:    return w3;
         GEN4:    return w4;
         GEN5:    return w5;
         default: return w1;
      endcase
   endfunction

endpackage

// File: rtl/valid_mask_dec.sv
// Thermometer decoder: a byte count becomes a mask with the low 'count' bits
// set. Counts at or above MAX_BYTES saturate to an all-ones mask.
module valid_mask_dec #(
   parameter int MAX_BYTES = 64,
   parameter int CNT_W     = 32
) (
   input  logic [CNT_W-1:0]     count,
   output logic [MAX_BYTES-1:0] mask
);

   // Each bit lights when its byte index lies below the count
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      mask = '0;
      for (int i = 0; i < MAX_BYTES; i++) begin
         mask[i] = (CNT_W'(i) < count);
      end
   end

endmodule

// File: rtl/gen_rate_ctrl.sv
// Generation/lane-width controller for the packet identifier datapath.
// Decodes negotiated generation and lane count into a byte-valid mask and
// sequences rate/width changes as drain -> reload -> resume.
module gen_rate_ctrl
   import gen_ctrl_pkg::*;
#(
   parameter int LANES          = 16,
   parameter int GEN1_PIPEWIDTH = 8,
   parameter int GEN2_PIPEWIDTH = 16,
   parameter int GEN3_PIPEWIDTH = 32,
   parameter int GEN4_PIPEWIDTH = 8,
   parameter int GEN5_PIPEWIDTH = 8,
   parameter int MAX_BYTES      = 64,
   parameter int DRAIN_CYCLES   = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [2:0]                   gen,
   input  logic [$clog2(LANES+1)-1:0]   active_lanes,
   input  logic                         hld_pd_gen,
   output logic [MAX_BYTES-1:0]         valid,
   output logic                         w,
   output logic                         sel,
   output logic                         rate_busy,
   output logic [2:0]                   cur_gen,
   output logic                         err
);

   localparam int LW = $clog2(LANES + 1);
   localparam int CW = $clog2(DRAIN_CYCLES + 1);
   localparam logic [LW-1:0] LANES_V     = LW'(LANES);
   localparam logic [CW-1:0] DRAIN_START = CW'(DRAIN_CYCLES - 1);

   logic [1:0]           state, state_nxt;
   logic [CW-1:0]        cnt, cnt_nxt;
   logic [2:0]           gen_q;
   logic [LW-1:0]        lanes_q;
   logic                 gen_ok;
   logic [2:0]           gen_dec;
   logic [LW-1:0]        lanes_eff;
   logic [31:0]          pw_bits;
   logic [31:0]          byte_cnt;
   logic [MAX_BYTES-1:0] mask_nxt;
   logic                 change;

   // Decode the live inputs into what a LOAD would capture
   always_comb begin
      gen_ok    = gen_legal(gen);
      gen_dec   = gen_ok ? gen : GEN1;
      lanes_eff = active_lanes;
      if (active_lanes == '0 || active_lanes > LANES_V) begin
         lanes_eff = LANES_V;
      end
      pw_bits  = 32'(pipewidth(gen_dec, GEN1_PIPEWIDTH, GEN2_PIPEWIDTH,
                                GEN3_PIPEWIDTH, GEN4_PIPEWIDTH, GEN5_PIPEWIDTH));
      byte_cnt = (32'(lanes_eff) * pw_bits) >> 3;
      // Compare raw inputs against the raw latched copies so an illegal gen
      // that was decoded as Gen1 does not look like a perpetual change.
      change   = (gen != gen_q) || (active_lanes != lanes_q);
   end

   valid_mask_dec #(
      .MAX_BYTES (MAX_BYTES),
      .CNT_W     (32)
   ) u_valid_mask_dec (
      .count (byte_cnt),
      .mask  (mask_nxt)
   );

   // Next-state and drain counter; hold beats a change request
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_HOLD: begin
            if (!hld_pd_gen) state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (hld_pd_gen) begin
               state_nxt = ST_HOLD;
            end else if (change) begin
               state_nxt = ST_DRAIN;
               cnt_nxt   = DRAIN_START;
            end
         end
         ST_DRAIN: begin
            if (hld_pd_gen) begin
               state_nxt = ST_HOLD;
               cnt_nxt   = '0;
            end else if (cnt == '0) begin
               state_nxt = ST_LOAD;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         default: begin
            state_nxt = ST_HOLD;
            cnt_nxt   = '0;
         end
      endcase
   end

   // State and counter registers
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      if (!rst) begin
         state <= ST_HOLD;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Configuration registers; they move only while in LOAD
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gen_q   <= '0;
         lanes_q <= '0;
         valid   <= '0;
         sel     <= 1'b0;
         cur_gen <= '0;
         err     <= 1'b0;
      end else if (state == ST_LOAD) begin
         gen_q   <= gen;
         lanes_q <= active_lanes;
         valid   <= mask_nxt;
         sel     <= (gen_dec >= GEN3);
         cur_gen <= gen_dec;
         err     <= !gen_ok;
      end
   end

   // Strobes decoded straight from the state register
   assign w         = (state == ST_RUN);
   assign rate_busy = (state == ST_DRAIN) || (state == ST_LOAD);

endmodule

// File: tb/tb_gen_rate_ctrl.sv
// Directed testbench for gen_rate_ctrl: a vector table of rate/width changes
// applied from RUN, plus hand-written hold, illegal-gen and reset sequences.
module tb_gen_rate_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  gen;
   logic [4:0]  active_lanes;
   logic        hld_pd_gen;
   logic [63:0] valid;
   logic        w;
   logic        sel;
   logic        rate_busy;
   logic [2:0]  cur_gen;
   logic        err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0]  gen;
      logic [4:0]  lanes;
      logic [63:0] valid;
      logic        sel;
      logic [2:0]  cur_gen;
      logic        err;
   } vec_t;

   vec_t vecs[10];

   gen_rate_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .gen          (gen),
      .active_lanes (active_lanes),
      .hld_pd_gen   (hld_pd_gen),
      .valid        (valid),
      .w            (w),
      .sel          (sel),
      .rate_busy    (rate_busy),
      .cur_gen      (cur_gen),
      .err          (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance one clock edge and settle just after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_cfg(input string tag, input logic [63:0] v, input logic s,
                            input logic [2:0] cg, input logic e);
      check({tag, " valid"},   valid,   v);
      check({tag, " sel"},     64'(sel), 64'(s));
      check({tag, " cur_gen"}, 64'(cur_gen), 64'(cg));
      check({tag, " err"},     64'(err), 64'(e));
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, " w"},         64'(w),         64'd0);
      check({tag, " rate_busy"}, 64'(rate_busy), 64'd0);
      check_cfg(tag, 64'd0, 1'b0, 3'd0, 1'b0);
   endtask

   logic [63:0] prev_valid;

   initial begin
      vecs[0] = '{3'd0, 5'd16, 64'h0000_0000_0000_FFFF, 1'b0, 3'd0, 1'b0};
      vecs[1] = '{3'd1, 5'd4,  64'h0000_0000_0000_00FF, 1'b0, 3'd1, 1'b0};
      vecs[2] = '{3'd1, 5'd0,  64'h0000_0000_FFFF_FFFF, 1'b0, 3'd1, 1'b0};
      vecs[3] = '{3'd2, 5'd1,  64'h0000_0000_0000_000F, 1'b1, 3'd2, 1'b0};
      vecs[4] = '{3'd3, 5'd16, 64'h0000_0000_0000_FFFF, 1'b1, 3'd3, 1'b0};
      vecs[5] = '{3'd4, 5'd3,  64'h0000_0000_0000_0007, 1'b1, 3'd4, 1'b0};
      vecs[6] = '{3'd2, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'd2, 1'b0};
      vecs[7] = '{3'd2, 5'd10, 64'h0000_00FF_FFFF_FFFF, 1'b1, 3'd2, 1'b0};
      vecs[8] = '{3'd6, 5'd16, 64'h0000_0000_0000_FFFF, 1'b0, 3'd0, 1'b1};
      vecs[9] = '{3'd1, 5'd2,  64'h0000_0000_0000_000F, 1'b0, 3'd1, 1'b0};

      // Reset with hold asserted
      rst          = 1'b0;
      hld_pd_gen   = 1'b1;
      gen          = 3'd2;
      active_lanes = 5'd16;
      #12;
      check_reset_outs("reset");
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check_reset_outs("hold idle");
      end

      // First load: gen=2, 16 lanes
      hld_pd_gen = 1'b0;
      step();
      check("load w",    64'(w),         64'd0);
      check("load busy", 64'(rate_busy), 64'd1);
      step();
      check("run w",    64'(w),         64'd1);
      check("run busy", 64'(rate_busy), 64'd0);
      check_cfg("first load", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'd2, 1'b0);
      prev_valid = 64'hFFFF_FFFF_FFFF_FFFF;

      // Table of changes applied from RUN
      for (int v = 0; v < 10; v++) begin
         gen          = vecs[v].gen;
         active_lanes = vecs[v].lanes;
         for (int c = 0; c < 5; c++) begin
            step();
            check($sformatf("vec%0d drain w", v),     64'(w),         64'd0);
            check($sformatf("vec%0d drain busy", v),  64'(rate_busy), 64'd1);
            check($sformatf("vec%0d drain valid", v), valid,          prev_valid);
         end
         step();
         check($sformatf("vec%0d w", v),    64'(w),         64'd1);
         check($sformatf("vec%0d busy", v), 64'(rate_busy), 64'd0);
         check_cfg($sformatf("vec%0d", v), vecs[v].valid, vecs[v].sel,
                   vecs[v].cur_gen, vecs[v].err);
         prev_valid = vecs[v].valid;
      end

      // Stable RUN stays put with no change pending
      for (int i = 0; i < 3; i++) begin
         step();
         check("steady w", 64'(w), 64'd1);
      end

      // Hold raised on the second DRAIN cycle
      gen          = 3'd0;
      active_lanes = 5'd2;
      step();
      step();
      hld_pd_gen = 1'b1;
      step();
      check("hold w",    64'(w),         64'd0);
      check("hold busy", 64'(rate_busy), 64'd0);
      check_cfg("hold", 64'h0000_0000_0000_000F, 1'b0, 3'd1, 1'b0);
      step();
      check("hold stays w", 64'(w), 64'd0);
      hld_pd_gen = 1'b0;
      step();
      check("reload busy", 64'(rate_busy), 64'd1);
      check("reload w",    64'(w),         64'd0);
      step();
      check("reload run w", 64'(w), 64'd1);
      check_cfg("reload", 64'h0000_0000_0000_0003, 1'b0, 3'd0, 1'b0);

      // Hold in RUN drops w at the next edge
      hld_pd_gen = 1'b1;
      step();
      check("run hold w", 64'(w), 64'd0);
      hld_pd_gen = 1'b0;
      step();
      step();
      check("rerun w", 64'(w), 64'd1);

      // Asynchronous reset in the middle of a drain
      gen          = 3'd2;
      active_lanes = 5'd16;
      step();
      step();
      check("pre-reset busy", 64'(rate_busy), 64'd1);
      rst = 1'b0;
      #1;
      check_reset_outs("async reset");
      hld_pd_gen = 1'b1;
      #3;
      rst = 1'b1;
      step();
      check_reset_outs("post reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
